pcs_40g_rx_am_lock: RTL and testbench
=====================================

Name: pcs_40g_rx_am_lock

Overview:
Per-lane 40GBASE-R receive alignment-marker lock block (IEEE 802.3 cl.82 am_lock). It sits after the per-lane 66b block sync, and before lane deskew/reorder and the descrambler. It finds the periodic alignment marker (AM) and identifies which of the 4 transmit lanes this physical lane carries. It holds lock with a mismatch tolerance, and flags AM blocks so downstream logic can strip them. It is the receive-side counterpart of the transmit AM insertion in pcs_40g_tx.

Parameters:
DATA_W, 64, block payload width
HEAD_W, 2, sync header width
LANE_N, 4, number of PCS lanes; lane_id width is $clog2(LANE_N)
AM_GAP, 16383, valid non-AM blocks between consecutive AMs; reduced only in simulation
AM_INVLD_MAX, 4, consecutive mismatching AMs that drop lock

Ports:
clk  in  1  clock
nreset  in  1  asynchronous active-low reset
block_lock_i  in  1  66b block lock from block sync; 0 forces relock
valid_i  in  1  head_i/data_i carry a block this cycle
head_i  in  HEAD_W  sync header
data_i  in  DATA_W  block payload, byte k at [8k+7:8k]
valid_o  out  1  registered valid_i
head_o  out  HEAD_W  registered head_i
data_o  out  DATA_W  registered data_i
am_v_o  out  1  block on data_o is a checked AM position while locked (strip it)
am_lock_o  out  1  AM lock achieved
lane_id_o  out  $clog2(LANE_N)  PCS lane number decoded from the locked AM
am_err_o  out  1  one-cycle pulse: AM position mismatched while locked

Behaviour:
- Reset is asynchronous and active-low. During reset all outputs are 0, the FSM is in INIT, and the counters are 0.
- Datapath latency is 1 cycle. valid_o, head_o, data_o, am_v_o and am_err_o are aligned to the same block.
- Only cycles with valid_i=1 advance any state. Cycles with valid_i=0 hold all state.
- AM match: head_i == SYNC_CTRL (2'b10). Bytes 0,1,2 equal M0..M2 of lane L. Bytes 4,5,6 equal ~M0..~M2. Bytes 3 and 7 (BIP) are ignored.
- M0..M2 values per lane:
  - lane0: 90 76 47
  - lane1: F0 C4 E6
  - lane2: C5 65 9B
  - lane3: A2 79 3D
- match_any is true if any lane matches. match_id is the index of the matching lane.
- FSM states:
  - INIT: clear all counters and outputs. Go to FIND_1ST when block_lock_i=1.
  - FIND_1ST: on a valid block with match_any, store first_id=match_id, clear gap_cnt, and go to COUNT_1.
  - COUNT_1: count valid blocks. When gap_cnt==AM_GAP, the next valid block is the check block:
    - if it matches first_id, go to LOCKED, set am_lock_o=1, set lane_id_o=first_id, clear invld_cnt;
    - otherwise go to FIND_1ST.
    - No AM stripping happens before LOCKED.
  - LOCKED: on every check block, am_v_o=1.
    - Match on lane_id_o: invld_cnt=0.
    - Otherwise: am_err_o=1 and invld_cnt increments. When it reaches AM_INVLD_MAX, am_lock_o=0 and go to FIND_1ST. That block is not flagged with am_v_o.
- In LOCKED, lane_id_o changes only on relock. A marker of a different lane counts as a mismatch.
- gap_cnt is $clog2(AM_GAP+1) bits wide. It is cleared on each check block and never wraps otherwise.
- block_lock_i=0 in any state: next cycle returns to INIT and am_lock_o=0. Any partial count is discarded.
- A marker appearing off-position is ignored in COUNT_1 and LOCKED.
- Simultaneous events: block_lock_i=0 takes priority over a check block.

Decomposition:
- Package pcs_40g_pkg holds:
  - SYNC_CTRL / SYNC_DATA header constants;
  - AM_M0_M2 array [LANE_N][3] of bytes (shared with the TX AM inserter);
  - the am_fsm_e enum;
  - the AM_GAP default.
- Sub-module pcs_40g_am_detect (combinational): takes head/data and outputs match_any, match_id and the per-lane match vector. It is reused by lane deskew.

Test Plan:
- Reset: assert nreset=0 mid-stream -> every output is 0 immediately; after release, am_lock_o stays 0 until two markers are seen.
- Acquire (AM_GAP=15): lane2 AM (C5 65 9B xx 3A 9A 64 xx, head 2'b10), then 15 data blocks, then lane2 AM -> am_lock_o=1 and lane_id_o=2 the cycle after the second AM; am_v_o=1 on later AMs.
- False first marker: lane1 AM, 15 blocks, then a data block -> stays unlocked in FIND_1ST; the next true lane1 pair locks with lane_id_o=1.
- Tolerance: once locked, corrupt 3 consecutive AMs (M1=00) then send a good AM -> am_err_o pulses 3 times and am_lock_o stays 1. Corrupting 4 consecutive AMs -> am_lock_o=0 after the 4th.
- Gaps and drop: valid_i=0 bubbles inserted randomly -> lock timing is unchanged in valid-block count. block_lock_i=0 for 1 cycle while locked -> am_lock_o=0 next cycle, and relock needs 2 new AMs.

Source files
------------

// File: rtl/pcs_40g_pkg.sv
// Shared 40GBASE-R PCS constants: sync headers, alignment marker bytes,
// the AM lock FSM encoding and the default marker spacing.
package pcs_40g_pkg;

    localparam int PCS_LANES = 4;

    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam logic [1:0] SYNC_DATA = 2'b01;

    // Valid non-AM blocks between consecutive markers on a lane.
    localparam int AM_GAP_DEF = 16383;

    // M0, M1, M2 per PCS lane; bytes 4..6 of a marker carry their complement.
    localparam logic [7:0] AM_M0_M2 [PCS_LANES][3] = '{
        '{8'h90, 8'h76, 8'h47},
        '{8'hF0, 8'hC4, 8'hE6},
        '{8'hC5, 8'h65, 8'h9B},
        '{8'hA2, 8'h79, 8'h3D}
    };

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_FIND_1ST = 2'd1,
        ST_COUNT_1  = 2'd2,
        ST_LOCKED   = 2'd3
    } am_fsm_e;

endpackage

// File: rtl/pcs_40g_am_detect.sv
// Combinational alignment-marker matcher: compares one 66b block against the
// marker pattern of every PCS lane. BIP bytes 3 and 7 are not compared.
module pcs_40g_am_detect
    import pcs_40g_pkg::*;
(
    input  logic [1:0]                     head,
    input  logic [63:0]                    data,
    output logic [PCS_LANES-1:0]           match_vec,
    output logic                           match_any,
    output logic [$clog2(PCS_LANES)-1:0]   match_id
);

    // Per-lane pattern compare, then lowest matching lane wins the id.
    always_comb begin
        match_vec = '0;
        match_id  = '0;
        for (int l = 0; l < PCS_LANES; l++) begin
            match_vec[l] = (head == SYNC_CTRL)
                        && (data[7:0]   == AM_M0_M2[l][0])
                        && (data[15:8]  == AM_M0_M2[l][1])
                        && (data[23:16] == AM_M0_M2[l][2])
                        && (data[39:32] == ~AM_M0_M2[l][0])
                        && (data[47:40] == ~AM_M0_M2[l][1])
                        && (data[55:48] == ~AM_M0_M2[l][2]);
        end
        for (int l = PCS_LANES - 1; l >= 0; l--) begin
            if (match_vec[l]) match_id = 2'(l);
        end
    end

    assign match_any = |match_vec;

endmodule

// File: rtl/pcs_40g_rx_am_lock.sv
// Per-lane receive alignment-marker lock. Finds two markers AM_GAP+1 valid
// blocks apart on the same PCS lane, then holds lock and flags every marker
// position, tolerating up to AM_INVLD_MAX-1 consecutive bad markers.
module pcs_40g_rx_am_lock
    import pcs_40g_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int HEAD_W       = 2,
    parameter int LANE_N       = 4,
    parameter int AM_GAP       = AM_GAP_DEF,
    parameter int AM_INVLD_MAX = 4
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      block_lock_i,
    input  logic                      valid_i,
    input  logic [HEAD_W-1:0]         head_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic                      valid_o,
    output logic [HEAD_W-1:0]         head_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      am_v_o,
    output logic                      am_lock_o,
    output logic [$clog2(LANE_N)-1:0] lane_id_o,
    output logic                      am_err_o
);

    localparam int GAP_W = $clog2(AM_GAP + 1);
    localparam int ID_W  = $clog2(LANE_N);
    localparam int INV_W = $clog2(AM_INVLD_MAX + 1);

    am_fsm_e            state, state_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_nx;
    logic [INV_W-1:0]   invld_cnt, invld_nx;
    logic [ID_W-1:0]    first_id, first_nx;
    logic [ID_W-1:0]    lane_nx;
    logic               lock_nx, am_v_nx, am_err_nx;

    logic [PCS_LANES-1:0] match_vec;
    logic                 match_any;
    logic [ID_W-1:0]      match_id;
    logic                 gap_done;

    pcs_40g_am_detect u_detect (
        .head      (head_i),
        .data      (data_i),
        .match_vec (match_vec),
        .match_any (match_any),
        .match_id  (match_id)
    );

    // The next valid block after AM_GAP counted blocks is the check block.
    assign gap_done = (gap_cnt == GAP_W'(AM_GAP));

    // Next-state and lock/flag decisions; loss of block lock overrides all.
    always_comb begin
        state_nx  = state;
        gap_nx    = gap_cnt;
        invld_nx  = invld_cnt;
        first_nx  = first_id;
        lane_nx   = lane_id_o;
        lock_nx   = am_lock_o;
        am_v_nx   = 1'b0;
        am_err_nx = 1'b0;
        if (!block_lock_i) begin
            state_nx = ST_INIT;
            gap_nx   = '0;
            invld_nx = '0;
            first_nx = '0;
            lane_nx  = '0;
            lock_nx  = 1'b0;
        end else if (valid_i) begin
            case (state)
                ST_INIT: begin
                    state_nx = ST_FIND_1ST;
                end
                ST_FIND_1ST: begin
                    if (match_any) begin
                        first_nx = match_id;
                        gap_nx   = '0;
                        state_nx = ST_COUNT_1;
                    end
                end
                ST_COUNT_1: begin
                    if (gap_done) begin
                        gap_nx = '0;
                        if (match_vec[first_id]) begin
                            state_nx = ST_LOCKED;
                            lock_nx  = 1'b1;
                            lane_nx  = first_id;
                            invld_nx = '0;
                        end else begin
                            state_nx = ST_FIND_1ST;
                        end
                    end else begin
                        gap_nx = gap_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (gap_done) begin
                        gap_nx = '0;
                        if (match_vec[lane_id_o]) begin
                            invld_nx = '0;
                            am_v_nx  = 1'b1;
                        end else if (invld_cnt == INV_W'(AM_INVLD_MAX - 1)) begin
                            // Last tolerated miss used up: drop lock, don't strip.
                            am_err_nx = 1'b1;
                            invld_nx  = '0;
                            lock_nx   = 1'b0;
                            state_nx  = ST_FIND_1ST;
                        end else begin
                            am_err_nx = 1'b1;
                            am_v_nx   = 1'b1;
                            invld_nx  = invld_cnt + 1'b1;
                        end
                    end else begin
                        gap_nx = gap_cnt + 1'b1;
                    end
                end
                default: state_nx = ST_INIT;
            endcase
        end
    end

    // FSM, counters and lock outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_INIT;
            gap_cnt   <= '0;
            invld_cnt <= '0;
            first_id  <= '0;
            lane_id_o <= '0;
            am_lock_o <= 1'b0;
            am_v_o    <= 1'b0;
            am_err_o  <= 1'b0;
        end else begin
            state     <= state_nx;
            gap_cnt   <= gap_nx;
            invld_cnt <= invld_nx;
            first_id  <= first_nx;
            lane_id_o <= lane_nx;
            am_lock_o <= lock_nx;
            am_v_o    <= am_v_nx;
            am_err_o  <= am_err_nx;
        end
    end

    // One-cycle pass-through of the block so flags line up with data_o.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_o <= 1'b0;
            head_o  <= '0;
            data_o  <= '0;
        end else begin
            valid_o <= valid_i;
            head_o  <= head_i;
            data_o  <= data_i;
        end
    end

endmodule

// File: tb/tb_pcs_40g_rx_am_lock.sv
// Bench for pcs_40g_rx_am_lock with a reduced marker gap. A block-level
// reference model predicts every output block; a monitor compares them.
module tb_pcs_40g_rx_am_lock;

    localparam int GAP = 15;
    localparam int INV = 4;
    localparam int EW  = 71;  // {head[2], data[64], am_v, am_err, lock, lane[2]}

    logic        clk = 1'b0;
    logic        nreset;
    logic        block_lock_i;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        am_v_o;
    logic        am_lock_o;
    logic [1:0]  lane_id_o;
    logic        am_err_o;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    pcs_40g_rx_am_lock #(
        .DATA_W(64), .HEAD_W(2), .LANE_N(4), .AM_GAP(GAP), .AM_INVLD_MAX(INV)
    ) dut (
        .clk(clk), .nreset(nreset), .block_lock_i(block_lock_i),
        .valid_i(valid_i), .head_i(head_i), .data_i(data_i),
        .valid_o(valid_o), .head_o(head_o), .data_o(data_o),
        .am_v_o(am_v_o), .am_lock_o(am_lock_o), .lane_id_o(lane_id_o),
        .am_err_o(am_err_o)
    );

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int err_seen = 0;
    bit bubble_en = 0;

    // ---------------- reference model ----------------
    bit m_init, m_anch, m_lock;
    int m_cand, m_since, m_miss, m_lane;

    function automatic logic [23:0] lane_pat(int lane);
        case (lane)
            0: return 24'h47_76_90;
            1: return 24'hE6_C4_F0;
            2: return 24'h9B_65_C5;
            default: return 24'h3D_79_A2;
        endcase
    endfunction

    function automatic logic [63:0] make_am(int lane, bit corrupt);
        logic [23:0] p, q;
        logic [7:0] b3, b7;
        p = lane_pat(lane);
        q = p;
        if (corrupt) q[15:8] = 8'h00;
        b3 = 8'($urandom);
        b7 = 8'($urandom);
        return {b7, ~p, b3, q};
    endfunction

    function automatic bit is_am(logic [1:0] h, logic [63:0] d, int lane);
        return (h == 2'b10) && (d[23:0] == lane_pat(lane)) && (d[55:32] == ~lane_pat(lane));
    endfunction

    task automatic model_reset();
        m_init = 1; m_anch = 0; m_lock = 0; m_since = 0; m_miss = 0; m_lane = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_i = 0; block_lock_i = 1;
            head_i = 2'($urandom); data_i = {$urandom, $urandom};
        end
    endtask

    task automatic drive(bit bl, logic [1:0] h, logic [63:0] d);
        bit av, ae;
        if (bubble_en) idle($urandom_range(0, 2));
        @(posedge clk); #1;
        valid_i = 1; block_lock_i = bl; head_i = h; data_i = d;
        av = 0; ae = 0;
        if (!bl) begin
            model_reset();
        end else if (m_init) begin
            m_init = 0;
        end else if (!m_anch) begin
            for (int l = 0; l < 4; l++) begin
                if (!m_anch && is_am(h, d, l)) begin
                    m_anch = 1; m_cand = l; m_since = 0;
                end
            end
        end else begin
            m_since++;
            if (m_since == GAP + 1) begin
                m_since = 0;
                if (!m_lock) begin
                    if (is_am(h, d, m_cand)) begin
                        m_lock = 1; m_lane = m_cand; m_miss = 0;
                    end else begin
                        m_anch = 0;
                    end
                end else if (is_am(h, d, m_lane)) begin
                    m_miss = 0; av = 1;
                end else begin
                    m_miss++; ae = 1;
                    if (m_miss == INV) begin
                        m_lock = 0; m_anch = 0; m_miss = 0;
                    end else begin
                        av = 1;
                    end
                end
            end
        end
        exp_q.push_back({h, d, av, ae, m_lock, (m_lock ? 2'(m_lane) : 2'd0)});
    endtask

    task automatic send_data(int n);
        repeat (n) drive(1, 2'b01, {$urandom, $urandom});
    endtask

    task automatic send_am(int lane, bit corrupt);
        drive(1, 2'b10, make_am(lane, corrupt));
    endtask

    task automatic drain();
        int n;
        idle(1);
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", name, got, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (nreset) begin
            if (valid_o) begin
                if (am_err_o) err_seen++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_block: got data=%h required=none", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({head_o, data_o} !== e[70:5]) begin
                        bad++;
                        $display("FAIL block_data: got=%h required=%h", {head_o, data_o}, e[70:5]);
                    end
                    total++;
                    if ({am_v_o, am_err_o, am_lock_o} !== e[4:2] ||
                        (e[2] && lane_id_o !== e[1:0])) begin
                        bad++;
                        $display("FAIL block_flags: got v/err/lock/lane=%b%b%b/%0d required=%b/%0d",
                                 am_v_o, am_err_o, am_lock_o, lane_id_o, e[4:2], e[1:0]);
                    end
                end
            end else begin
                total++;
                if (am_v_o || am_err_o) begin
                    bad++;
                    $display("FAIL idle_flags: got v/err=%b%b required=00", am_v_o, am_err_o);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int e0, tgt, r;
        nreset = 0; block_lock_i = 0; valid_i = 0; head_i = 0; data_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({valid_o, head_o, am_v_o, am_lock_o, lane_id_o, am_err_o, |data_o}), 64'd0);
        nreset = 1; block_lock_i = 1;

        // Acquire on lane 2.
        send_data(2); send_am(2, 0); send_data(GAP); send_am(2, 0);
        drain();
        chk("acq_lock", 64'(am_lock_o), 64'd1);
        chk("acq_lane", 64'(lane_id_o), 64'd2);
        send_data(GAP); send_am(2, 0); send_data(GAP); send_am(2, 0);
        drain();
        chk("locked_hold", 64'(am_lock_o), 64'd1);

        // Block lock loss drops AM lock.
        drive(0, 2'b01, {$urandom, $urandom});
        drain();
        chk("drop_lock", 64'(am_lock_o), 64'd0);

        // False first marker, then a true lane 1 pair.
        send_data(2); send_am(1, 0); send_data(GAP); send_data(1);
        drain();
        chk("false_first", 64'(am_lock_o), 64'd0);
        send_am(1, 0); send_data(GAP); send_am(1, 0);
        drain();
        chk("relock_lock", 64'(am_lock_o), 64'd1);
        chk("relock_lane", 64'(lane_id_o), 64'd1);

        // Three bad markers are tolerated.
        e0 = err_seen;
        repeat (3) begin send_data(GAP); send_am(1, 1); end
        send_data(GAP); send_am(1, 0);
        drain();
        chk("tol3_errs", 64'(err_seen - e0), 64'd3);
        chk("tol3_lock", 64'(am_lock_o), 64'd1);

        // Four bad markers drop lock.
        e0 = err_seen;
        repeat (4) begin send_data(GAP); send_am(1, 1); end
        drain();
        chk("tol4_errs", 64'(err_seen - e0), 64'd4);
        chk("tol4_lock", 64'(am_lock_o), 64'd0);

        // Lock with random bubbles on lane 3.
        bubble_en = 1;
        send_data(3); send_am(3, 0); send_data(GAP); send_am(3, 0);
        drain();
        chk("bubble_lock", 64'(am_lock_o), 64'd1);
        chk("bubble_lane", 64'(lane_id_o), 64'd3);

        // Mid-stream reset.
        @(posedge clk); #1;
        nreset = 0;
        #1;
        chk("midreset_outputs", 64'({valid_o, head_o, am_v_o, am_lock_o, lane_id_o, am_err_o, |data_o}), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 nreset = 1;
        send_data(2); send_am(0, 0); send_data(GAP);
        drain();
        chk("after_reset_unlocked", 64'(am_lock_o), 64'd0);
        send_am(0, 0);
        drain();
        chk("after_reset_lane", 64'({am_lock_o, lane_id_o}), 64'({1'b1, 2'd0}));

        // Randomized periods: wrong lanes, corruption, stray markers, drops.
        tgt = 0;
        for (int p = 0; p < 40; p++) begin
            for (int k = 0; k < GAP; k++) begin
                if ($urandom_range(0, 15) == 0) send_am($urandom_range(0, 3), 0);
                else send_data(1);
            end
            r = $urandom_range(0, 9);
            if (r < 6)       send_am(tgt, 0);
            else if (r < 8)  send_am(tgt, 1);
            else if (r < 9)  send_am($urandom_range(0, 3), 0);
            else             drive(1, 2'b10, {$urandom, $urandom});
            if ($urandom_range(0, 19) == 0) begin
                drive(0, 2'b01, {$urandom, $urandom});
                send_data(1);
            end
            if ($urandom_range(0, 9) == 0) tgt = $urandom_range(0, 3);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
